// File: rtl/icache_resp_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache responder.
package icache_resp_pkg;

    // PC reported on icache_pc_o before the first returned instruction.
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Refill engine states.
    typedef enum logic [0:0] {
        StIdle,
        StRefill
    } refill_state_e;

    // Bits selecting a word within a line.
    function automatic int unsigned offset_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Bits selecting a set; SETS is expected to be a power of two, at least 2.
    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Remaining upper PC bits above byte offset, word offset and index.
    function automatic int unsigned tag_w(input int unsigned line_words,
                                          input int unsigned sets);
        return 32 - 2 - offset_w(line_words) - index_w(sets);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill engine: tracks the miss base address, walks the beat counter across one
// line, drives the memory request/address and tells the cache when to write words and
// when the line is complete.
module icache_refill_fsm
    import icache_resp_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned OffsetW = offset_w(LINE_WORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,     // miss accepted in idle
    input  logic [31:0]        miss_pc_i,
    input  logic               mem_valid_i,
    output logic               busy_o,      // refill in progress
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        base_o,      // line base of the refill target
    output logic               word_we_o,   // write mem data into word beat_o
    output logic [OffsetW-1:0] beat_o,
    output logic               line_done_o  // last word written this cycle
);

    localparam logic [OffsetW-1:0] LastBeat = OffsetW'(LINE_WORDS - 1);
    localparam logic [31:0]        LineMask = ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

    refill_state_e      state_q, state_d;
    logic [OffsetW-1:0] beat_q, beat_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        addr_q, addr_d;
    logic               word_we, line_done;

    // Next-state: latch the line base on a miss, then count beats as memory delivers them.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        addr_d    = addr_q;
        word_we   = 1'b0;
        line_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRefill;
                    beat_d  = '0;
                    base_d  = miss_pc_i & LineMask;
                    addr_d  = miss_pc_i & LineMask;
                end
            end
            StRefill: begin
                if (mem_valid_i) begin
                    word_we = 1'b1;
                    if (beat_q == LastBeat) begin
                        line_done = 1'b1;
                        state_d   = StIdle;
                        beat_d    = '0;
                        addr_d    = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        addr_d = base_q + {{(30 - OffsetW){1'b0}}, beat_d, 2'b00};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, beat counter, base and memory address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
        end
    end

    // Request and stall follow the state flop directly, so they drop in the cycle
    // after the last beat and clear immediately on reset.
    assign busy_o      = (state_q == StRefill);
    assign mem_req_o   = (state_q == StRefill);
    assign mem_addr_o  = addr_q;
    assign base_o      = base_q;
    assign word_we_o   = word_we;
    assign beat_o      = beat_q;
    assign line_done_o = line_done;

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache answering the fetch stage. Hits return the instruction
// one cycle after the request; misses stall flow control while one line is refilled.
module icache_resp
    import icache_resp_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc_i,
    input  logic        if_req_Icache_i,
    input  logic        if_jump_Icache_i,
    output logic [31:0] icache_inst_o,
    output logic        icache_inst_valid_o,
    output logic [31:0] icache_pc_o,
    output logic        icache_jump_o,
    output logic        icache_stall_fc_o,
    output logic        icache_mem_req_o,
    output logic [31:0] icache_mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_valid_i
);

    localparam int unsigned OffsetW = offset_w(LINE_WORDS);
    localparam int unsigned IndexW  = index_w(SETS);
    localparam int unsigned TagW    = tag_w(LINE_WORDS, SETS);

    // Request address fields.
    logic [OffsetW-1:0] req_off;
    logic [IndexW-1:0]  req_idx;
    logic [TagW-1:0]    req_tag;

    assign req_off = if_pc_i[2 +: OffsetW];
    assign req_idx = if_pc_i[2 + OffsetW +: IndexW];
    assign req_tag = if_pc_i[31 -: TagW];

    // Refill engine interface.
    logic               busy;
    logic               word_we;
    logic               line_done;
    logic [OffsetW-1:0] beat;
    logic [31:0]        fill_base;
    logic [IndexW-1:0]  fill_idx;
    logic [TagW-1:0]    fill_tag;

    assign fill_idx = fill_base[2 + OffsetW +: IndexW];
    assign fill_tag = fill_base[31 -: TagW];

    // Byte offset of the PC and the in-line bits of the base carry no information.
    logic unused_bits;
    assign unused_bits = ^{if_pc_i[1:0], fill_base[1 + OffsetW:0]};

    // Line storage: valid bits are reset, tags and data are plain flop arrays.
    logic [SETS-1:0] valid_q, valid_d;
    logic [TagW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS][LINE_WORDS];

    // Lookup is only performed in idle; requests seen during a refill are dropped.
    logic lookup, hit, miss_start;

    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lookup     = if_req_Icache_i && !busy;
    assign miss_start = lookup && !hit;

    icache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (miss_start),
        .miss_pc_i   (if_pc_i),
        .mem_valid_i (mem_valid_i),
        .busy_o      (busy),
        .mem_req_o   (icache_mem_req_o),
        .mem_addr_o  (icache_mem_addr_o),
        .base_o      (fill_base),
        .word_we_o   (word_we),
        .beat_o      (beat),
        .line_done_o (line_done)
    );

    assign icache_stall_fc_o = busy;

    // Valid bits: the target set is invalidated as the refill starts so a partially
    // written line can never hit, and is marked valid with the last beat.
    always_comb begin
        valid_d = valid_q;
        if (miss_start) begin
            valid_d[req_idx] = 1'b0;
        end
        if (line_done) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Response registers: a hit captures the word, its PC and the jump flag.
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        jump_q, jump_d;

    // Next response: updated only on a hit, held otherwise.
    always_comb begin
        inst_valid_d = lookup && hit;
        inst_d       = inst_q;
        pc_d         = pc_q;
        jump_d       = jump_q;
        if (inst_valid_d) begin
            inst_d = data_q[req_idx][req_off];
            pc_d   = if_pc_i;
            jump_d = if_jump_Icache_i;
        end
    end

    // Reset-bearing state: valid bits and all response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pc_q         <= RESET_PC;
            jump_q       <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            jump_q       <= jump_d;
        end
    end

    // Tag and data arrays are written by the refill engine only.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[fill_idx][beat] <= mem_data_i;
        end
        if (line_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    assign icache_inst_o       = inst_q;
    assign icache_inst_valid_o = inst_valid_q;
    assign icache_pc_o         = pc_q;
    assign icache_jump_o       = jump_q;

endmodule

// File: tb/tb_icache_resp.sv
// Scoreboard bench for icache_resp: a driver issues fetch requests and predicts hit/miss
// from a line-level model, a memory responder serves refills, and a monitor compares
// every returned instruction against the queued expectation.
module tb_icache_resp;

    localparam int unsigned LW   = 4;
    localparam int unsigned SETS = 64;
    localparam int unsigned LINE_BYTES = 4 * LW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic        if_req_Icache_i;
    logic        if_jump_Icache_i;
    logic [31:0] icache_inst_o;
    logic        icache_inst_valid_o;
    logic [31:0] icache_pc_o;
    logic        icache_jump_o;
    logic        icache_stall_fc_o;
    logic        icache_mem_req_o;
    logic [31:0] icache_mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i;

    always #5 clk = ~clk;

    icache_resp #(
        .LINE_WORDS (LW),
        .SETS       (SETS)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_pc_i             (if_pc_i),
        .if_req_Icache_i     (if_req_Icache_i),
        .if_jump_Icache_i    (if_jump_Icache_i),
        .icache_inst_o       (icache_inst_o),
        .icache_inst_valid_o (icache_inst_valid_o),
        .icache_pc_o         (icache_pc_o),
        .icache_jump_o       (icache_jump_o),
        .icache_stall_fc_o   (icache_stall_fc_o),
        .icache_mem_req_o    (icache_mem_req_o),
        .icache_mem_addr_o   (icache_mem_addr_o),
        .mem_data_i          (mem_data_i),
        .mem_valid_i         (mem_valid_i)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory image: explicit words for directed tests, a hash elsewhere.
    logic [31:0] img [logic [31:0]];

    function automatic logic [31:0] backing(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (img.exists(w)) return img[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Line-level cache model: which tag each set holds.
    bit          mvalid [SETS];
    logic [31:0] mtag   [SETS];

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 32'(LINE_BYTES)) % 32'(SETS));
    endfunction

    function automatic logic [31:0] mtagof(input logic [31:0] pc);
        return pc / 32'(LINE_BYTES * SETS);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(SETS); i++) mvalid[i] = 1'b0;
    endtask

    // Scoreboard of expected returned instructions.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
    } exp_t;

    exp_t sb[$];

    // Monitor: every presented instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && icache_inst_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_inst: actual pc=%h inst=%h required no instruction",
                         icache_pc_o, icache_inst_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inst", icache_inst_o, e.inst);
                chk("inst_pc", icache_pc_o, e.pc);
                chk("inst_jump", 32'(icache_jump_o), 32'(e.jump));
            end
        end
    end

    // Memory responder: serves refill beats, either alternating with idle cycles or
    // with random gaps, and checks the requested address against the expected beat.
    logic [31:0] exp_base = '0;
    int          rsp_beat = 0;
    int          last_beat_cycle = -1;
    bit          gap_mode = 1'b0;
    bit          gap_tog  = 1'b0;

    initial begin
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        forever begin
            bit go;
            @(posedge clk);
            #1;
            if (mem_valid_i && rst_n) begin
                rsp_beat++;
                if (rsp_beat == int'(LW)) last_beat_cycle = cycle;
            end
            mem_valid_i = 1'b0;
            if (rst_n && icache_mem_req_o) begin
                if (gap_mode) begin
                    gap_tog = !gap_tog;
                    go      = gap_tog;
                end else begin
                    go = ($urandom_range(0, 2) != 0);
                end
                if (go) begin
                    chk("mem_addr", icache_mem_addr_o, exp_base + 32'(4 * rsp_beat));
                    mem_valid_i = 1'b1;
                    mem_data_i  = backing(icache_mem_addr_o);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one request; on a predicted miss, wait out the refill (optionally pulsing a
    // request that must be dropped) and check the stall window.
    task automatic do_req(input logic [31:0] pc, input logic jump, input bit pulse_drop);
        int          idx;
        logic [31:0] tg;
        bit          hit;
        int          n;
        idx = midx(pc);
        tg  = mtagof(pc);
        hit = mvalid[idx] && (mtag[idx] == tg);
        if_req_Icache_i  = 1'b1;
        if_pc_i          = pc;
        if_jump_Icache_i = jump;
        if (hit) begin
            sb.push_back('{inst: backing(pc), pc: pc, jump: jump});
        end else begin
            exp_base = pc & ~32'(LINE_BYTES - 1);
            rsp_beat = 0;
            gap_tog  = 1'b0;
        end
        step();
        if_req_Icache_i = 1'b0;
        if (hit) begin
            chk("hit_valid", 32'(icache_inst_valid_o), 32'd1);
            chk("hit_stall", 32'(icache_stall_fc_o), 32'd0);
        end else begin
            chk("miss_stall", 32'(icache_stall_fc_o), 32'd1);
            chk("miss_valid", 32'(icache_inst_valid_o), 32'd0);
            mvalid[idx] = 1'b0;
            n = 0;
            while (icache_stall_fc_o && n < 200) begin
                if (pulse_drop && n == 2) begin
                    if_req_Icache_i  = 1'b1;
                    if_pc_i          = 32'h0000_0010;
                    if_jump_Icache_i = 1'b1;
                end else begin
                    if_req_Icache_i = 1'b0;
                end
                step();
                n++;
            end
            if_req_Icache_i = 1'b0;
            chk("refill_timeout", 32'(icache_stall_fc_o), 32'd0);
            chk("refill_beats", 32'(rsp_beat), 32'(LW));
            chk("stall_fall_cycle", 32'(cycle), 32'(last_beat_cycle));
            chk("req_after_refill", 32'(icache_mem_req_o), 32'd0);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
    endtask

    // Start a refill, then assert reset once two beats have been accepted.
    task automatic reset_mid_refill(input logic [31:0] pc);
        int n;
        if_req_Icache_i  = 1'b1;
        if_pc_i          = pc;
        if_jump_Icache_i = 1'b0;
        exp_base = pc & ~32'(LINE_BYTES - 1);
        rsp_beat = 0;
        step();
        if_req_Icache_i = 1'b0;
        chk("rmr_stall", 32'(icache_stall_fc_o), 32'd1);
        n = 0;
        while (rsp_beat < 2 && n < 200) begin
            step();
            n++;
        end
        chk("rmr_two_beats", 32'(rsp_beat >= 2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmr_mem_req", 32'(icache_mem_req_o), 32'd0);
        chk("rmr_stall_clear", 32'(icache_stall_fc_o), 32'd0);
        chk("rmr_inst_valid", 32'(icache_inst_valid_o), 32'd0);
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n            = 1'b1;
        if_req_Icache_i  = 1'b0;
        if_pc_i          = '0;
        if_jump_Icache_i = 1'b0;
        model_clear();
        img[32'h0000_0000] = 32'h11;
        img[32'h0000_0004] = 32'h22;
        img[32'h0000_0008] = 32'h33;
        img[32'h0000_000C] = 32'h44;
        img[32'h0000_0400] = 32'hA0;
        img[32'h0000_0404] = 32'hA1;
        img[32'h0000_0408] = 32'hA2;
        img[32'h0000_040C] = 32'hA3;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_inst_valid", 32'(icache_inst_valid_o), 32'd0);
        chk("rst_inst", icache_inst_o, 32'd0);
        chk("rst_pc", icache_pc_o, 32'd0);
        chk("rst_jump", 32'(icache_jump_o), 32'd0);
        chk("rst_stall", 32'(icache_stall_fc_o), 32'd0);
        chk("rst_mem_req", 32'(icache_mem_req_o), 32'd0);
        chk("rst_mem_addr", icache_mem_addr_o, 32'd0);
        rst_n = 1'b1;
        step();

        // Cold miss with one idle cycle between beats, then re-request.
        gap_mode = 1'b1;
        do_req(32'h0000_0000, 1'b0, 1'b0);
        gap_mode = 1'b0;
        do_req(32'h0000_0000, 1'b0, 1'b0);

        // Streaming hits on consecutive cycles.
        do_req(32'h0000_0004, 1'b0, 1'b0);
        do_req(32'h0000_0008, 1'b0, 1'b0);
        do_req(32'h0000_000C, 1'b0, 1'b0);

        // Jump flag forwarded on a hit.
        do_req(32'h0000_0008, 1'b1, 1'b0);

        // Conflict eviction in set 0, then the old line misses again with a dropped
        // request pulsed during its refill.
        do_req(32'h0000_0400, 1'b0, 1'b0);
        do_req(32'h0000_0400, 1'b0, 1'b0);
        do_req(32'h0000_0000, 1'b0, 1'b1);
        do_req(32'h0000_0000, 1'b0, 1'b0);
        do_req(32'h0000_0010, 1'b0, 1'b0);
        do_req(32'h0000_0010, 1'b1, 1'b0);

        // Reset mid-refill discards all lines.
        reset_mid_refill(32'h0000_0800);
        do_req(32'h0000_0000, 1'b0, 1'b0);
        do_req(32'h0000_0000, 1'b0, 1'b0);

        // Random traffic over a few sets and tags so hits and conflicts mix.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                 (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_req(pc, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
